// File: rtl/add_subb_ser_pkg.sv
// Package for add_subb_ser: state type built on the shared header encodings
// and a helper for the digit-counter width.
package add_subb_ser_pkg;

  `include "add_subb_defs.vh"

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Counter must hold the value N without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/add_subb_defs.vh
// Shared encodings for the serial add/subtract block: FSM state codes and
// the width of the inter-digit carry register.
`ifndef ADD_SUBB_DEFS_VH
`define ADD_SUBB_DEFS_VH

localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_RUN  = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;

// Carry between digits can reach 2 (two inverted operands each add a +1).
localparam int CARRY_W = 2;

`endif

// File: rtl/add_subb_digit.sv
// One D-bit digit slice of the serial adder: D-bit operands plus a carry of
// 0..2 in, D-bit sum and a carry of 0..2 out.
module add_subb_digit
  import add_subb_ser_pkg::*;
#(
  parameter int D = 2
) (
  input  logic [D-1:0]       x,
  input  logic [D-1:0]       y,
  input  logic [CARRY_W-1:0] cin,
  output logic [D-1:0]       sum,
  output logic [CARRY_W-1:0] cout
);

  logic [D+1:0] total;

  // Widest case 2*(2^D-1)+2 = 2^(D+1) still fits in D+2 bits.
  always_comb begin
    total = {2'b00, x} + {2'b00, y} + {{D{1'b0}}, cin};
    sum   = total[D-1:0];
    cout  = total[D+1:D];
  end

endmodule

// File: rtl/add_subb_ser.sv
// Digit-serial signed add/subtract: {c,s} = (a^{W{subb_a}}) + (b^{W{subb_b}})
// + subb_a + subb_b, D bits per cycle, LSB first.
// Optional feature: define ADD_SUBB_SER_OVF_EN to add the signed-overflow output ovf.
module add_subb_ser
  import add_subb_ser_pkg::*;
#(
  parameter int W = 4,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         subb_a,
  input  logic         subb_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c
`ifdef ADD_SUBB_SER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int N  = W / D;
  localparam int CW = cnt_width(N);

  if ((W % D) != 0 || D < 1) begin : g_bad_param
    $error("add_subb_ser: W must be a positive multiple of D");
  end

  // Handshake: operands transfer on an enabled edge with in_valid && in_ready;
  // the result transfers on an enabled edge with out_valid && out_ready.
  // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap.
  state_t             state;
  logic [W-1:0]       opa;
  logic [W-1:0]       opb;
  logic [CARRY_W-1:0] carry;
  logic [CW-1:0]      cnt;

  logic [D-1:0]       dig_a;
  logic [D-1:0]       dig_b;
  logic [D-1:0]       dig_sum;
  logic [CARRY_W-1:0] dig_cout;
  int                 lo;
  logic               last_digit;

  always_comb begin
    lo         = int'(cnt) * D;
    dig_a      = opa[lo +: D];
    dig_b      = opb[lo +: D];
    last_digit = (cnt == CW'(N - 1));
  end

  add_subb_digit #(.D(D)) u_digit (
    .x    (dig_a),
    .y    (dig_b),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

`ifdef ADD_SUBB_SER_OVF_EN
  logic               ovf_hold;
  logic signed [W+1:0] ext_a;
  logic signed [W+1:0] ext_b;
  logic signed [W+1:0] ext_sum;
  logic               ovf_calc;

  // Exact signed (+/-a)+(+/-b) in W+2 bits; it fits W bits iff the top three agree.
  always_comb begin
    ext_a = {{2{a[W-1]}}, a};
    ext_b = {{2{b[W-1]}}, b};
    if (subb_a) ext_a = -ext_a;
    if (subb_b) ext_b = -ext_b;
    ext_sum  = ext_a + ext_b;
    ovf_calc = (ext_sum[W+1:W-1] != {3{ext_sum[W-1]}});
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      carry     <= '0;
      cnt       <= '0;
      s         <= '0;
      c         <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef ADD_SUBB_SER_OVF_EN
      ovf_hold  <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa      <= a ^ {W{subb_a}};
            opb      <= b ^ {W{subb_b}};
            carry    <= {1'b0, subb_a} + {1'b0, subb_b};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef ADD_SUBB_SER_OVF_EN
            ovf_hold <= ovf_calc;
`endif
          end
        end
        RUN: begin
          s[lo +: D] <= dig_sum;
          carry      <= dig_cout;
          cnt        <= cnt + 1'b1;
          if (last_digit) begin
            c         <= dig_cout[0];
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef ADD_SUBB_SER_OVF_EN
            ovf       <= ovf_hold;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_subb_ser.sv
// Directed bench for add_subb_ser at W=4, D=2 with hand-computed results.
module tb_add_subb_ser;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic         subb_a;
  logic         subb_b;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c;
`ifdef ADD_SUBB_SER_OVF_EN
  logic         ovf;
`endif

  int n_checks;
  int n_pass;

  add_subb_ser #(.W(W), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .subb_a    (subb_a),
    .subb_b    (subb_b),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c         (c)
`ifdef ADD_SUBB_SER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic sa, input logic sb,
                     input logic [W-1:0] exp_s, input logic exp_c, input logic exp_ovf);
    check({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb; subb_a = sa; subb_b = sb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = '0; b = '0; subb_a = 1'b0; subb_b = 1'b0;
    check({tag, "_busy"}, in_ready, 0);
    wait_valid(tag, 2);
    check({tag, "_s"}, s, exp_s);
    check({tag, "_c"}, c, exp_c);
`ifdef ADD_SUBB_SER_OVF_EN
    check({tag, "_ovf"}, ovf, exp_ovf);
`else
    if (exp_ovf !== exp_ovf) $display("unreachable");
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drained"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    subb_a = 1'b0; subb_b = 1'b0; a = '0; b = '0;
    repeat (3) step();
    rst = 1'b1;
    check("reset_outputs", {in_ready, out_valid, c, s}, {1'b1, 1'b0, 1'b0, 4'b0000});

    // main function
    txn("add_3_2",    4'd3, 4'd2, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
    txn("sub_3_2",    4'd3, 4'd2, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
    txn("neg_1_1",    4'd1, 4'd1, 1'b1, 1'b1, 4'b1110, 1'b1, 1'b0);
    txn("ovf_7_1",    4'd7, 4'd1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
    // -(-8) = +8 overflows; carry-out bit W is 0
    txn("neg_min",    4'b1000, 4'd0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);
    // -0 - 0: carry register ends at 2, so c = bit0 = 0
    txn("neg_zeros",  4'd0, 4'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    txn("add_m1_m1",  4'hF, 4'hF, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0);

    // hold in DONE with out_ready=0 while toggling in_valid and ena
    a = 4'd3; b = 4'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid("hold", 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      ena = i[0];
      a = 4'd9; b = 4'd6;
      step();
      check("hold_outputs", {out_valid, in_ready, c, s}, {1'b1, 1'b0, 1'b0, 4'b0101});
    end
    ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold_release", {in_ready, out_valid}, 2'b10);

    // ena=0 during RUN freezes progress
    a = 4'd1; b = 4'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ena = 1'b0;
    repeat (3) step();
    check("ena_freeze", out_valid, 0);
    ena = 1'b1;
    wait_valid("ena_resume", 2);
    check("ena_resume_s", s, 4'b0011);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset during the first RUN cycle discards the operation
    a = 4'd7; b = 4'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst_run", {in_ready, out_valid, c, s}, {1'b1, 1'b0, 1'b0, 4'b0000});
    repeat (4) step();
    check("rst_discard", {in_ready, out_valid}, 2'b10);
    txn("after_rst", 4'd3, 4'd2, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
